ga25_bus_master: RTL
====================

Name: ga25_bus_master

Overview:
- CPU-side initiator for the GA25 video chip's VRAM port (mem_cs/mem_rd/mem_wr/busy handshake).
- Accepts one word request at a time from the CPU bus glue and sequences the GA25 edge-triggered access protocol, including the mandatory idle gap between accesses.
- Provides byte-lane writes by read-modify-write, since GA25 writes full 16-bit words only.
- Returns read data and a completion ack; a watchdog timeout flags an error.

Parameters:
- TIMEOUT, 1024, clk cycles allowed from request assertion to busy falling before abort.
- GAP_CYCLES, 2, minimum clk cycles with the request deasserted between consecutive GA25 accesses (minimum legal value 1).

Ports:
- clk  in  1  system clock (same clock as GA25 clk)
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  request strobe; sampled only in IDLE
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  16  byte address; bit 0 ignored
- cpu_wdata  in  16  write data
- cpu_be  in  2  byte enables; [1]=high byte, [0]=low byte
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  valid with cpu_ack; 1=timeout abort
- cpu_rdata  out  16  read data; valid from cpu_ack until next read completes
- mem_cs  out  1  GA25 chip select
- mem_rd  out  1  GA25 read strobe
- mem_wr  out  1  GA25 write strobe
- mem_addr  out  16  to GA25 addr
- mem_dout  out  16  to GA25 cpu_din
- mem_din  in  16  from GA25 cpu_dout
- busy  in  1  from GA25 busy

Behaviour:
- Reset: all outputs 0; state IDLE; gap counter preloaded to GAP_CYCLES; timeout counter 0. Reset mid-access drops all strobes in the same cycle. The resulting GA25-side state is GA25's own reset's concern.
- All outputs are registered. mem_cs, mem_rd and mem_wr only change on state transitions.
- States and transitions:
  - IDLE: while gap counter < GAP_CYCLES, increment it and ignore cpu_req. Once the gap is met and cpu_req=1, latch addr, wdata, be and we, then branch:
    - read: go to RD_ISSUE.
    - write with be=11: go to WR_ISSUE, mem_dout=wdata.
    - write with be=01 or 10: go to RD_ISSUE with flag rmw=1.
    - write with be=00: no bus activity; cpu_ack=1 and cpu_err=0 next cycle.
  - RD_ISSUE: drive mem_cs=1, mem_rd=1. GA25 raises busy 1 clk after sampling the request. Ignore busy=0 until busy has been seen high (seen_busy flag). When busy=1, go to RD_WAIT.
  - RD_WAIT: hold the strobes. On the first cycle busy=0, capture mem_din and drop the strobes.
    - If rmw=0: cpu_rdata=captured value, pulse ack, go to GAP.
    - If rmw=1: merge, taking each enabled byte from wdata and each disabled byte from the captured value, into mem_dout; go to GAP with pending write.
  - GAP: counter reset to 0, return to IDLE-gap logic. With a pending write, proceed to WR_ISSUE once GAP_CYCLES elapse, without waiting for cpu_req.
  - WR_ISSUE / WR_WAIT: same as read, using mem_wr=1. On busy falling, pulse ack and go to GAP. cpu_rdata is unchanged by writes.
- Timeout:
  - The counter runs from entry to RD_ISSUE or WR_ISSUE.
  - If it reaches TIMEOUT without completion, drop the strobes, pulse cpu_ack with cpu_err=1, clear rmw/pending, and go to GAP.
  - On an RMW abort, no write is issued.
- The watchdog also covers a pathological busy that is already high at issue: busy=1 seen at issue counts as seen_busy.
- cpu_req held high after ack starts a new access only after the gap. The bench/glue must drop cpu_req on ack to avoid repeats.
- mem_addr=cpu_addr latched, with bit 0 forced 0. It is stable for the entire access, including both halves of an RMW.

Test Plan:
- Read at addr 0x1234 with GA25 model returning 0xBEEF: mem_rd held until busy falls → cpu_rdata=0xBEEF, one ack, err=0, mem_addr=0x1234 throughout.
- Full write of 0xA55A to 0x0100: single mem_wr access, mem_dout=0xA55A. No mem_rd pulse.
- Byte write be=10, wdata=0x12xx, to a word holding 0x3456: read access, then GAP_CYCLES of strobes low, then write of 0x1256. Exactly one ack, after the write.
- Back-to-back reads with cpu_req held high: strobes low for ≥GAP_CYCLES between accesses. GA25 accepts both (two busy pulses observed).
- Busy delayed one clk (and, separately, by GA25's 16-ce rowscroll window): no premature completion while busy is still 0 at issue; data is captured on the busy falling edge.
- Busy never asserted: after TIMEOUT clks, ack with err=1, strobes low. Next request is serviced normally. Assert reset mid-RMW: all outputs 0 the next cycle, no write issued.

Source files
------------

// File: rtl/ga25_bus_master_if.sv
// CPU request/response and GA25 VRAM port signals of ga25_bus_master.
// The master modport is the initiator's view; slave is the CPU glue / GA25 side.
interface ga25_bus_master_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [1:0]  cpu_be;
  logic        cpu_ack;
  logic        cpu_err;
  logic [15:0] cpu_rdata;
  logic        mem_cs;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_dout;
  logic [15:0] mem_din;
  logic        busy;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_din, busy,
    output cpu_ack, cpu_err, cpu_rdata, mem_cs, mem_rd, mem_wr, mem_addr, mem_dout
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_din, busy,
    input  cpu_ack, cpu_err, cpu_rdata, mem_cs, mem_rd, mem_wr, mem_addr, mem_dout
  );
endinterface

// File: rtl/ga25_bus_master.sv
// CPU-side initiator for the GA25 VRAM port: sequences edge-triggered accesses,
// enforces the idle gap between them and emulates byte writes by read-modify-write.
module ga25_bus_master #(
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  ga25_bus_master_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_MET = GW'(GAP_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    GAP      = 3'd3,
    WR_ISSUE = 3'd4,
    WR_WAIT  = 3'd5
  } state_t;

  state_t      state_r;
  logic [GW-1:0] gap_cnt_r;
  logic [TW-1:0] to_cnt_r;
  logic        rmw_r;
  logic        pending_r;
  logic [1:0]  be_r;
  logic [15:0] wdata_r;
  logic        cpu_ack_r;
  logic        cpu_err_r;
  logic [15:0] cpu_rdata_r;
  logic        mem_cs_r;
  logic        mem_rd_r;
  logic        mem_wr_r;
  logic [15:0] mem_addr_r;
  logic [15:0] mem_dout_r;

  logic gap_met_s;
  logic to_hit_s;
  logic in_wait_s;

  // Enabled lanes come from the CPU write data, the rest from the word read back.
  function automatic logic [15:0] merge_bytes(input logic [1:0]  be,
                                              input logic [15:0] wdata,
                                              input logic [15:0] old);
    merge_bytes = {(be[1] ? wdata[15:8] : old[15:8]),
                   (be[0] ? wdata[7:0]  : old[7:0])};
  endfunction

  assign gap_met_s = (gap_cnt_r >= GAP_MET);
  assign to_hit_s  = (to_cnt_r == TO_LAST);
  assign in_wait_s = (state_r == RD_WAIT) || (state_r == WR_WAIT);

  // Access sequencer: gap pacing, issue/wait handshake, RMW merge and watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      gap_cnt_r   <= GAP_MET;
      to_cnt_r    <= '0;
      rmw_r       <= 1'b0;
      pending_r   <= 1'b0;
      be_r        <= 2'b00;
      wdata_r     <= 16'h0000;
      cpu_ack_r   <= 1'b0;
      cpu_err_r   <= 1'b0;
      cpu_rdata_r <= 16'h0000;
      mem_cs_r    <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= 16'h0000;
      mem_dout_r  <= 16'h0000;
    end else begin
      cpu_ack_r <= 1'b0;
      cpu_err_r <= 1'b0;
      case (state_r)
        IDLE, GAP: begin
          if (!gap_met_s) begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end else if (pending_r) begin
            // Second half of an RMW goes out without waiting for the CPU.
            pending_r <= 1'b0;
            to_cnt_r  <= '0;
            mem_cs_r  <= 1'b1;
            mem_wr_r  <= 1'b1;
            state_r   <= WR_ISSUE;
          end else if (bus.cpu_req) begin
            mem_addr_r <= {bus.cpu_addr[15:1], 1'b0};
            wdata_r    <= bus.cpu_wdata;
            be_r       <= bus.cpu_be;
            to_cnt_r   <= '0;
            if (!bus.cpu_we) begin
              rmw_r    <= 1'b0;
              mem_cs_r <= 1'b1;
              mem_rd_r <= 1'b1;
              state_r  <= RD_ISSUE;
            end else begin
              case (bus.cpu_be)
                2'b11: begin
                  mem_dout_r <= bus.cpu_wdata;
                  mem_cs_r   <= 1'b1;
                  mem_wr_r   <= 1'b1;
                  state_r    <= WR_ISSUE;
                end
                2'b01, 2'b10: begin
                  rmw_r    <= 1'b1;
                  mem_cs_r <= 1'b1;
                  mem_rd_r <= 1'b1;
                  state_r  <= RD_ISSUE;
                end
                default: begin
                  cpu_ack_r <= 1'b1;
                  state_r   <= IDLE;
                end
              endcase
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT: begin
          if (in_wait_s && !bus.busy) begin
            mem_cs_r  <= 1'b0;
            mem_rd_r  <= 1'b0;
            mem_wr_r  <= 1'b0;
            gap_cnt_r <= '0;
            state_r   <= GAP;
            if ((state_r == RD_WAIT) && rmw_r) begin
              mem_dout_r <= merge_bytes(be_r, wdata_r, bus.mem_din);
              pending_r  <= 1'b1;
              rmw_r      <= 1'b0;
            end else if (state_r == RD_WAIT) begin
              cpu_rdata_r <= bus.mem_din;
              cpu_ack_r   <= 1'b1;
            end else begin
              cpu_ack_r <= 1'b1;
            end
          end else if (to_hit_s) begin
            mem_cs_r  <= 1'b0;
            mem_rd_r  <= 1'b0;
            mem_wr_r  <= 1'b0;
            cpu_ack_r <= 1'b1;
            cpu_err_r <= 1'b1;
            rmw_r     <= 1'b0;
            pending_r <= 1'b0;
            gap_cnt_r <= '0;
            state_r   <= GAP;
          end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
            // Busy seen high in an issue state (even if already high) arms the wait.
            if (bus.busy && (state_r == RD_ISSUE)) begin
              state_r <= RD_WAIT;
            end else if (bus.busy && (state_r == WR_ISSUE)) begin
              state_r <= WR_WAIT;
            end else begin
              state_r <= state_r;
            end
          end
        end
        default: begin
          mem_cs_r  <= 1'b0;
          mem_rd_r  <= 1'b0;
          mem_wr_r  <= 1'b0;
          rmw_r     <= 1'b0;
          pending_r <= 1'b0;
          gap_cnt_r <= '0;
          state_r   <= GAP;
        end
      endcase
    end
  end

  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.cpu_err   = cpu_err_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.mem_cs    = mem_cs_r;
  assign bus.mem_rd    = mem_rd_r;
  assign bus.mem_wr    = mem_wr_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_dout  = mem_dout_r;
endmodule
